// File: rtl/mdu_seq_pkg.sv
// Shared definitions for the multiply/divide unit: opcodes, default latencies,
// control state encoding and counter sizing.
package mdu_seq_pkg;

    typedef enum logic [2:0] {
        MDU_MULT  = 3'd0,
        MDU_MULTU = 3'd1,
        MDU_DIV   = 3'd2,
        MDU_DIVU  = 3'd3,
        MDU_MTHI  = 3'd4,
        MDU_MTLO  = 3'd5,
        MDU_MFHI  = 3'd6,
        MDU_MFLO  = 3'd7
    } mdu_op_e;

    localparam int unsigned MDU_MULT_CYCLES = 5;
    localparam int unsigned MDU_DIV_CYCLES  = 10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mdu_state_e;

    // Counter must hold the larger of the two latencies.
    function automatic int unsigned cnt_width(input int unsigned mult_cyc,
                                              input int unsigned div_cyc);
        return $clog2(((mult_cyc > div_cyc) ? mult_cyc : div_cyc) + 1);
    endfunction

endpackage

// File: rtl/mdu_seq_arith.sv
// Combinational datapath: full-width product, quotient/remainder (truncating
// toward zero, remainder signed like the dividend) and divide-by-zero flag.
module mdu_arith
    import mdu_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [2:0]         op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] prod,
    output logic [WIDTH-1:0]   quot,
    output logic [WIDTH-1:0]   rem,
    output logic               div_by_zero
);

    logic               is_signed;
    logic [2*WIDTH-1:0] a_ext;
    logic [2*WIDTH-1:0] b_ext;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH-1:0]   b_div;
    logic [WIDTH-1:0]   q_mag;
    logic [WIDTH-1:0]   r_mag;

    // Sign-magnitude division; the -2^(W-1) / -1 case falls out naturally as
    // a magnitude quotient of 2^(W-1) whose bit pattern is -2^(W-1).
    always_comb begin
        is_signed   = (op == MDU_MULT) || (op == MDU_DIV);
        a_ext       = is_signed ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
        b_ext       = is_signed ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
        prod        = a_ext * b_ext;
        a_neg       = is_signed & a[WIDTH-1];
        b_neg       = is_signed & b[WIDTH-1];
        a_mag       = a_neg ? -a : a;
        b_mag       = b_neg ? -b : b;
        div_by_zero = (b == '0);
        b_div       = div_by_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : b_mag;
        q_mag       = a_mag / b_div;
        r_mag       = a_mag % b_div;
        quot        = (a_neg ^ b_neg) ? -q_mag : q_mag;
        rem         = a_neg ? -r_mag : r_mag;
    end

endmodule

// File: rtl/mdu_seq.sv
// Multi-cycle multiply/divide unit: HI/LO registers, shadow result held for
// the configured latency, busy/countdown control, cancel and mt/mf access.
module mdu_seq
    import mdu_seq_pkg::*;
#(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned MULT_CYCLES = MDU_MULT_CYCLES,
    parameter int unsigned DIV_CYCLES  = MDU_DIV_CYCLES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] mf_out
);

    localparam int unsigned CNT_W = cnt_width(MULT_CYCLES, DIV_CYCLES);

    mdu_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [WIDTH-1:0]   sh_hi_q, sh_hi_d;
    logic [WIDTH-1:0]   sh_lo_q, sh_lo_d;

    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quot;
    logic [WIDTH-1:0]   rem;
    logic               div_by_zero;
    logic               is_md;
    logic               is_mult;

    mdu_arith #(.WIDTH(WIDTH)) u_arith (
        .op          (op),
        .a           (a),
        .b           (b),
        .prod        (prod),
        .quot        (quot),
        .rem         (rem),
        .div_by_zero (div_by_zero)
    );

    assign is_md   = ~op[2];
    assign is_mult = (op[2:1] == 2'b00);

    // State register: control, countdown, architectural and shadow HI/LO.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            sh_hi_q <= '0;
            sh_lo_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            sh_hi_q <= sh_hi_d;
            sh_lo_q <= sh_lo_d;
        end
    end

    // Next state in priority order: cancel, completion, launch, mt write.
    // A divide by zero snapshots the current HI/LO so completion is a no-op
    // (mt is blocked while busy, so HI/LO cannot move in between).
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        sh_hi_d = sh_hi_q;
        sh_lo_d = sh_lo_q;
        if (cancel) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            sh_hi_d = '0;
            sh_lo_d = '0;
        end else if (state_q == ST_BUSY) begin
            if (cnt_q == CNT_W'(1)) begin
                hi_d    = sh_hi_q;
                lo_d    = sh_lo_q;
                cnt_d   = '0;
                state_d = ST_IDLE;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end else if (start && is_md) begin
            state_d = ST_BUSY;
            cnt_d   = is_mult ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
            if (is_mult) begin
                {sh_hi_d, sh_lo_d} = prod;
            end else if (div_by_zero) begin
                sh_hi_d = hi_q;
                sh_lo_d = lo_q;
            end else begin
                sh_hi_d = rem;
                sh_lo_d = quot;
            end
        end else if (op == MDU_MTHI) begin
            hi_d = a;
        end else if (op == MDU_MTLO) begin
            lo_d = a;
        end
    end

    // Move-from read port and status outputs.
    always_comb begin
        mf_out = '0;
        if (op == MDU_MFHI) begin
            mf_out = hi_q;
        end else if (op == MDU_MFLO) begin
            mf_out = lo_q;
        end
    end

    assign busy = (state_q == ST_BUSY);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_seq.sv
// Scoreboard bench for mdu_seq: stimulus pushes expected HI/LO and busy
// length; a negedge monitor pops and compares whenever busy falls.
module tb_mdu_seq;
    import mdu_seq_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, cancel, busy;
    logic [2:0]  op;
    logic [31:0] a, b, hi, lo, mf_out;
    logic        start1, cancel1, busy1;
    logic [2:0]  op1;
    logic [31:0] a1, b1, hi1, lo1, mf_out1;

    always #5 clk = ~clk;

    mdu_seq #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .cancel(cancel), .busy(busy), .hi(hi), .lo(lo), .mf_out(mf_out)
    );

    mdu_seq #(.WIDTH(32), .MULT_CYCLES(1), .DIV_CYCLES(1)) d1 (
        .clk(clk), .reset(reset), .start(start1), .op(op1), .a(a1), .b(b1),
        .cancel(cancel1), .busy(busy1), .hi(hi1), .lo(lo1), .mf_out(mf_out1)
    );

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int unsigned cyc;
    } exp_t;

    exp_t        sbq[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    bit          mon_en   = 1'b0;
    bit          prev_busy = 1'b0;
    int unsigned busy_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1; op = o; a = x; b = y;
        tick();
        start = 1'b0; op = MDU_MFHI;
    endtask

    task automatic mt(input logic [2:0] o, input logic [31:0] x);
        op = o; a = x;
        tick();
        op = MDU_MFHI;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40 && busy; i++) tick();
        check("wait_idle", 64'(busy), 64'(0));
    endtask

    // Monitor: count busy cycles, compare on the falling edge of busy.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                busy_cnt = 0;
            end else if (busy) begin
                busy_cnt++;
            end else if (prev_busy) begin
                if (sbq.size() == 0) begin
                    check("unexpected_completion", 64'(1), 64'(0));
                end else begin
                    e = sbq.pop_front();
                    check("sb_hi", 64'(hi), 64'(e.hi));
                    check("sb_lo", 64'(lo), 64'(e.lo));
                    check("sb_busy_cycles", 64'(busy_cnt), 64'(e.cyc));
                end
                busy_cnt = 0;
            end
            prev_busy = mon_en ? busy : 1'b0;
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; cancel = 1'b0; op = MDU_MFHI; a = '0; b = '0;
        start1 = 1'b0; cancel1 = 1'b0; op1 = MDU_MFHI; a1 = '0; b1 = '0;
        #12 reset = 1'b0;
        tick();
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_hi", 64'(hi), 64'(0));
        check("rst_lo", 64'(lo), 64'(0));
        check("rst_mf", 64'(mf_out), 64'(0));
        check("rst_busy1", 64'(busy1), 64'(0));
        mon_en = 1'b1;

        sbq.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFE, 5});
        launch(MDU_MULT, 32'hFFFF_FFFF, 32'd2);
        wait_idle();
        sbq.push_back('{32'h0000_0001, 32'hFFFF_FFFE, 5});
        launch(MDU_MULTU, 32'hFFFF_FFFF, 32'd2);
        wait_idle();
        sbq.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFD, 10});
        launch(MDU_DIV, 32'hFFFF_FFF9, 32'd2);
        wait_idle();
        sbq.push_back('{32'd1, 32'd3, 10});
        launch(MDU_DIVU, 32'd7, 32'd2);
        wait_idle();

        mt(MDU_MTHI, 32'h1234);
        #1 check("mfhi", 64'(mf_out), 64'h1234);
        op = MDU_MFLO;
        #1 check("mflo", 64'(mf_out), 64'd3);
        op = MDU_MTHI;
        #1 check("mf_other_op", 64'(mf_out), 64'd0);
        op = MDU_MFHI;

        // mtlo/mthi while busy must be ignored
        sbq.push_back('{32'd0, 32'd12, 5});
        launch(MDU_MULT, 32'd3, 32'd4);
        op = MDU_MTLO; a = 32'hDEAD;
        tick(); tick();
        op = MDU_MTHI; a = 32'hBEEF;
        tick();
        op = MDU_MFHI;
        check("mt_busy_lo", 64'(lo), 64'd3);
        check("mt_busy_hi", 64'(hi), 64'h1234);
        check("mt_busy_still", 64'(busy), 64'(1));
        wait_idle();

        // divide by zero keeps preloaded HI/LO
        mt(MDU_MTHI, 32'd5);
        mt(MDU_MTLO, 32'd6);
        sbq.push_back('{32'd5, 32'd6, 10});
        launch(MDU_DIV, 32'd100, 32'd0);
        wait_idle();
        sbq.push_back('{32'd0, 32'h8000_0000, 10});
        launch(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle();

        // cancel sampled on the third edge after launch
        sbq.push_back('{32'd0, 32'h8000_0000, 3});
        launch(MDU_MULT, 32'd7, 32'd9);
        tick(); tick();
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        check("cancel_busy", 64'(busy), 64'(0));
        check("cancel_hi", 64'(hi), 64'd0);
        check("cancel_lo", 64'(lo), 64'h8000_0000);
        tick(); tick();
        sbq.push_back('{32'd0, 32'd63, 5});
        launch(MDU_MULT, 32'd7, 32'd9);
        wait_idle();

        // cancel with start on the same edge: no launch
        cancel = 1'b1; start = 1'b1; op = MDU_MULT; a = 32'd5; b = 32'd5;
        tick();
        cancel = 1'b0; start = 1'b0; op = MDU_MFHI;
        check("cancel_start_busy", 64'(busy), 64'(0));
        tick();
        check("cancel_start_lo", 64'(lo), 64'd63);

        // start with a non-md opcode is ignored
        start = 1'b1; op = MDU_MFLO;
        tick();
        start = 1'b0; op = MDU_MFHI;
        check("start_op7_busy", 64'(busy), 64'(0));

        // start held high: second launch accepted at k+N+1, not earlier
        sbq.push_back('{32'd0, 32'd6, 5});
        sbq.push_back('{32'd0, 32'd10, 5});
        start = 1'b1; op = MDU_MULTU; a = 32'd2; b = 32'd3;
        tick();
        a = 32'd5; b = 32'd2;
        repeat (5) tick();
        check("b2b_gap", 64'(busy), 64'(0));
        tick();
        start = 1'b0; op = MDU_MFHI;
        check("b2b_relaunch", 64'(busy), 64'(1));
        wait_idle();

        // asynchronous reset mid-divide
        mt(MDU_MTHI, 32'h77);
        launch(MDU_DIV, 32'd100, 32'd7);
        tick(); tick();
        mon_en = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("arst_busy", 64'(busy), 64'(0));
        check("arst_hi", 64'(hi), 64'd0);
        check("arst_lo", 64'(lo), 64'd0);
        #3 reset = 1'b0;
        tick();
        check("sb_drained", 64'(sbq.size()), 64'd0);

        // single-cycle latency instance
        start1 = 1'b1; op1 = MDU_MULT; a1 = 32'd6; b1 = 32'd7;
        tick();
        start1 = 1'b0; op1 = MDU_MFLO;
        check("c1_mult_busy", 64'(busy1), 64'(1));
        tick();
        check("c1_mult_done", 64'(busy1), 64'(0));
        check("c1_mult_lo", 64'(mf_out1), 64'd42);
        check("c1_mult_hi", 64'(hi1), 64'd0);
        start1 = 1'b1; op1 = MDU_DIV; a1 = 32'hFFFF_FFF9; b1 = 32'd2;
        tick();
        start1 = 1'b0; op1 = MDU_MFHI;
        check("c1_div_busy", 64'(busy1), 64'(1));
        tick();
        check("c1_div_done", 64'(busy1), 64'(0));
        check("c1_div_lo", 64'(lo1), 64'hFFFF_FFFD);
        check("c1_div_hi", 64'(hi1), 64'hFFFF_FFFF);
        start1 = 1'b1; op1 = MDU_MULT; a1 = 32'd6; b1 = 32'd7;
        tick();
        start1 = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("c1_arst_busy", 64'(busy1), 64'(0));
        check("c1_arst_hi", 64'(hi1), 64'd0);
        check("c1_arst_lo", 64'(lo1), 64'd0);
        #3 reset = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
